uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmit stage: accepts one parallel byte per valid/ready handshake and drives a framed serial line.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits.
- Sits directly upstream of the board TX pin and downstream of the byte source (FIFO or command logic).
- Internally it uses a right-shifting parallel-in/serial-out register and a baud-period counter.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, line rate. Derived CLKS_PER_BIT = CLK_HZ/BAUD, integer divide (434 at defaults); must be ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  DATA_BITS  byte to send; sampled only on the accept edge.
- valid  input  1  data is presented.
- ready  output  1  block can accept a byte; transfer occurs when valid and ready are both high at a rising edge.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is in flight; equals ~ready.

Behaviour:
- Reset: synchronous, active-high. At the rst edge: state=IDLE, tx=1, ready=1, busy=0, counters=0.
- Reset mid-frame aborts the frame: tx=1 on the reset edge and the byte is discarded.
- States: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE: tx=1, ready=1.
  - On an accept edge: load data into the shift register, clear the baud counter and bit counter, go to START.
  - tx drives 0 from that same edge.
- Baud counter: counts 0..CLKS_PER_BIT-1. The terminal count (bit_done) ends the current bit. The counter is cleared at accept, so every bit lasts exactly CLKS_PER_BIT cycles.
- START: tx=0. On bit_done, go to DATA with tx=shift[0].
- DATA: tx=shift[0].
  - On bit_done: shift right (fill 1), increment the bit counter.
  - After the DATA_BITS-th bit, go to PARITY (if compiled in), else STOP.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - On the final bit_done, go to IDLE and set ready=1 on that edge.
- Frame length in cycles = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT, where P = 1 with parity, else 0.
- Back-to-back frames: if valid is high at the first IDLE cycle, the next start bit begins one cycle after the stop bit ends. Idle gap between frames is exactly 1 clock.
- valid while ready=0 is ignored. data need not be held after the accept edge.
- No glitches: tx comes straight from a flop.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - At accept, compute the parity bit: XOR of data, inverted if PARITY_ODD.
  - PARITY state drives that bit for CLKS_PER_BIT cycles between DATA and STOP.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Decomposition:
- Shared header common.vh:
  - existing DIR_UP/DIR_DOWN and SHIFT_DIR_LEFT/RIGHT constants.
  - new UART_ST_IDLE, UART_ST_START, UART_ST_DATA, UART_ST_PARITY, UART_ST_STOP state encodings (3-bit), shared with a future uart_rx.
- Sub-module baud_tick_gen:
  - parameters CLKS_PER_BIT; ports clk, rst, clr, tick.
  - synchronous-reset counter with a 1-cycle tick at terminal count.
  - reused by uart_rx.
- Shift register and bit counter: inline, synchronous reset.

Test Plan (CLK_HZ=1600, BAUD=100 → 16 clocks/bit, 8N1 unless noted):
- After reset, hold idle 50 cycles → tx=1, ready=1, busy=0 throughout.
- Send 0x55 → tx = 0,1,0,1,0,1,0,1,0,1, each held 16 cycles. ready=0 for exactly 160 cycles; ready rises on cycle 160 after accept.
- Send 0xA3 then 0x0F with valid held high → second start bit begins 1 cycle after first stop ends. A bench deserializer recovers 0xA3, 0x0F.
- Assert rst 70 cycles into a 0x00 frame → tx=1 and ready=1 on the reset edge; no further low bits appear.
- Toggle valid with changing data while busy → ignored; only the originally accepted byte is transmitted.
- With UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 → parity bit = 1; frame 176 cycles. With PARITY_ODD=1 → parity bit = 0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path. uart_tx imports this package, and a future
// uart_rx is meant to reuse it.
// Optional feature macro consumed by uart_tx: UART_TX_PARITY_EN.
package uart_tx_pkg;

  // Direction constants shared with other blocks in the codebase.
  localparam logic DIR_UP          = 1'b0;
  localparam logic DIR_DOWN        = 1'b1;
  localparam logic SHIFT_DIR_LEFT  = 1'b0;
  localparam logic SHIFT_DIR_RIGHT = 1'b1;

  // UART state encodings. These are fixed so that tx and rx report the same codes.
  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = UART_ST_IDLE,
    StStart  = UART_ST_START,
    StData   = UART_ST_DATA,
    StParity = UART_ST_PARITY,
    StStop   = UART_ST_STOP
  } uart_state_e;

  // Clock cycles per bit. Integer division truncates toward zero.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-period counter. It counts 0..CLKS_PER_BIT-1 and pulses tick for one cycle at the terminal
// count. clr restarts the period so that the next tick arrives exactly CLKS_PER_BIT cycles later.
// uart_rx is meant to reuse this block.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  // Free-running period counter; synchronous reset and clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. It accepts one byte per valid/ready handshake and sends a frame made of a
// start bit, DATA_BITS data bits (LSB first), an optional parity bit, and STOP_BITS stop bits.
// The tx output comes straight from a flop.
// Optional feature macro: UART_TX_PARITY_EN. It inserts a parity bit, which is even when
// PARITY_ODD=0 and odd when PARITY_ODD=1.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam logic [2:0]  LastData     = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LastStop     = 3'(STOP_BITS - 1);

  // Elaboration-time parameter checks.
  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_chk_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  uart_state_e          state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 accept;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign ready  = (state_q == StIdle);
  assign busy   = ~ready;
  assign accept = valid & ready;
  assign tx     = tx_q;

  // The period counter restarts at accept, so the start bit lasts a full CLKS_PER_BIT cycles.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .tick(bit_done)
  );

  // Next-state logic for the frame sequencer, the shift register, the bit counter and the line.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d   = data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^data) ^ PARITY_ODD[0];
`endif
        end
      end
      StStart: begin
        if (bit_done) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          // Right shift, filling with 1 so the vacated bits look like idle line.
          shift_d = {1'b1, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d      = parity_q;
            state_d   = StParity;
`else
            tx_d      = 1'b1;
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_d[0];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (bit_cnt_q == LastStop) begin
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  // State registers. Reset aborts any frame in flight and returns the line to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at 16 clocks per bit (CLK_HZ=1600, BAUD=100).
// Expected line values are built from the frame layout: start bit, 8 data bits LSB first,
// an optional parity bit, then 1 stop bit.
module tb_uart_tx;

  localparam int unsigned CLK_HZ = 1600;
  localparam int unsigned BAUD   = 100;
  localparam int          CPB    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int          PBITS  = 1;
`else
  localparam int          PBITS  = 0;
`endif
  localparam int          FRAME  = (1 + 8 + PBITS + 1) * CPB;
  localparam int          LOGLEN = 2 * FRAME + 24;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       ready, tx, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .busy (busy)
  );

`ifdef UART_TX_PARITY_EN
  logic valid_odd = 1'b0;
  logic ready_odd, tx_odd, busy_odd;

  uart_tx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY_ODD(1)
  ) dut_odd (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .valid(valid_odd),
    .ready(ready_odd),
    .tx   (tx_odd),
    .busy (busy_odd)
  );
`endif

  // Expected line level k cycles after the accept edge of a frame carrying b.
  function automatic logic exp_tx(input logic [7:0] b, input int k, input logic odd);
    int bitn;
    bitn = k / CPB;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    if (PBITS == 1 && bitn == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  // Present one byte and return #1 after its accept edge (k = 0). The data bus is scrambled
  // afterwards to show that it need not be held.
  task automatic do_accept(input logic [7:0] b);
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data  = ~b;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
               tx, ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_hold: %0d bad cycles out of 50, required 0", bad);
    end
  endtask

  task automatic test_single_55();
    do_accept(8'h55);
    for (int k = 0; k <= FRAME; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k < FRAME) begin
        checks++;
        if (tx !== exp_tx(8'h55, k, 1'b0) || ready !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL frame_55 k=%0d: tx=%b ready=%b busy=%b, required tx=%b ready=0 busy=1",
                   k, tx, ready, busy, exp_tx(8'h55, k, 1'b0));
        end
      end else begin
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
          failures++;
          $display("FAIL ready_rise_55 k=%0d: ready=%b busy=%b tx=%b, required 1 0 1",
                   k, ready, busy, tx);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       tx_log [LOGLEN];
    logic [7:0] rec    [4];
    logic       e;
    int         nrec;
    int         idx;
    @(negedge clk);
    data  = 8'hA3;
    valid = 1'b1;
    @(posedge clk);
    #1;
    data = 8'h0F;
    for (int k = 0; k < LOGLEN; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      tx_log[k] = tx;
      if (k < FRAME) e = exp_tx(8'hA3, k, 1'b0);
      else if (k == FRAME) e = 1'b1;
      else if (k < 2 * FRAME + 1) e = exp_tx(8'h0F, k - FRAME - 1, 1'b0);
      else e = 1'b1;
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL b2b_line k=%0d: tx=%b, required %b", k, tx, e);
      end
      if (k == FRAME) begin
        checks++;
        if (ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_gap_ready: ready=%b, required 1", ready);
        end
      end
      if (k == FRAME + 1) begin
        checks++;
        if (ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_second_accept: ready=%b, required 0", ready);
        end
        valid = 1'b0;
      end
    end
    // Deserialize the captured line by sampling at mid-bit.
    nrec = 0;
    idx  = 0;
    while (idx + FRAME <= LOGLEN) begin
      if (tx_log[idx] === 1'b0 && nrec < 4) begin
        for (int j = 0; j < 8; j++) rec[nrec][j] = tx_log[idx + CPB / 2 + CPB * (j + 1)];
        nrec++;
        idx += FRAME;
      end else begin
        idx++;
      end
    end
    checks++;
    if (nrec != 2) begin
      failures++;
      $display("FAIL b2b_count: recovered %0d bytes, required 2", nrec);
    end else begin
      checks++;
      if (rec[0] !== 8'hA3 || rec[1] !== 8'h0F) begin
        failures++;
        $display("FAIL b2b_bytes: got %h %h, required a3 0f", rec[0], rec[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    do_accept(8'h00);
    for (int k = 1; k < 70; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_flight: tx=%b busy=%b, required tx=0 busy=1", tx, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_edge: tx=%b ready=%b busy=%b, required 1 1 0", tx, ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < FRAME + 40; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || ready !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL mid_abort: %0d non-idle cycles after reset, required 0", lows);
    end
  endtask

  task automatic test_ignore_busy();
    logic e;
    do_accept(8'h3C);
    for (int k = 0; k < FRAME + 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      e = (k < FRAME) ? exp_tx(8'h3C, k, 1'b0) : 1'b1;
      checks++;
      if (tx !== e) begin
        failures++;
        $display("FAIL ignore_busy k=%0d: tx=%b, required %b", k, tx, e);
      end
      if (k >= FRAME) begin
        checks++;
        if (ready !== 1'b1) begin
          failures++;
          $display("FAIL ignore_busy_ready k=%0d: ready=%b, required 1", k, ready);
        end
      end
      // Wiggle valid and data while busy; stop well before the frame ends.
      if (k < FRAME - 10) begin
        valid = k[0];
        data  = 8'(k * 37);
      end else begin
        valid = 1'b0;
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    // 0x07 has three set bits: even parity bit = 1, odd parity bit = 0.
    do_accept(8'h07);
    for (int k = 0; k <= FRAME; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k >= 9 * CPB && k < 10 * CPB) begin
        checks++;
        if (tx !== 1'b1) begin
          failures++;
          $display("FAIL parity_even k=%0d: tx=%b, required 1", k, tx);
        end
      end else if (k < FRAME) begin
        checks++;
        if (tx !== exp_tx(8'h07, k, 1'b0) || ready !== 1'b0) begin
          failures++;
          $display("FAIL parity_frame k=%0d: tx=%b ready=%b, required tx=%b ready=0",
                   k, tx, ready, exp_tx(8'h07, k, 1'b0));
        end
      end else begin
        checks++;
        if (ready !== 1'b1) begin
          failures++;
          $display("FAIL parity_len: ready=%b at cycle %0d, required 1", ready, k);
        end
      end
    end
    @(negedge clk);
    data      = 8'h07;
    valid_odd = 1'b1;
    @(posedge clk);
    #1;
    valid_odd = 1'b0;
    for (int k = 0; k <= FRAME; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k >= 9 * CPB && k < 10 * CPB) begin
        checks++;
        if (tx_odd !== 1'b0) begin
          failures++;
          $display("FAIL parity_odd k=%0d: tx=%b, required 0", k, tx_odd);
        end
      end else if (k == FRAME) begin
        checks++;
        if (ready_odd !== 1'b1) begin
          failures++;
          $display("FAIL parity_odd_len: ready=%b, required 1", ready_odd);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_55();
    repeat (5) @(posedge clk);
    test_back_to_back();
    repeat (5) @(posedge clk);
    test_reset_mid();
    test_ignore_busy();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
